// File: rtl/psg_multichannel.sv
// Multichannel programmable sound generator: square/noise tone channels programmed over a
// nibble bus, a shared prescaler tick, and a registered PCM mix of the active channel volumes.
module psg_multichannel #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned PERIOD_W = 12,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned MIX_W    = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [3:0]        D,
  input  logic              A0,
  input  logic              WR,
  output logic [NUM_CH-1:0] CH_OUT,
  output logic [MIX_W-1:0]  MIX,
  output logic              TICK
);

  localparam int unsigned PresW = $clog2(PRESCALE);

  logic [3:0]                       addr_q, addr_d;
  logic [PresW-1:0]                 presc_q, presc_d;
  logic [NUM_CH-1:0][PERIOD_W-1:0]  period_q, period_d;
  logic [NUM_CH-1:0][2:0]           vol_q, vol_d;
  logic [NUM_CH-1:0]                mode_q, mode_d;
  logic [NUM_CH-1:0][PERIOD_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0]                phase_q, phase_d;
  logic [NUM_CH-1:0][14:0]          lfsr_q, lfsr_d;
  logic [MIX_W-1:0]                 mix_q, mix_d;
  logic                             tick;
  logic                             wr_data;
  logic [11:0]                      per_full;

  assign tick    = (presc_q == PresW'(PRESCALE - 1));
  assign wr_data = WR & ~A0;

  always_comb begin
    addr_d   = addr_q;
    presc_d  = tick ? '0 : presc_q + PresW'(1);
    period_d = period_q;
    vol_d    = vol_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    lfsr_d   = lfsr_q;
    mix_d    = '0;
    per_full = '0;

    if (WR) begin
      addr_d = A0 ? D : addr_q + 4'd1;
    end

    for (int unsigned c = 0; c < NUM_CH; c++) begin
      // Register writes land in *_d only; the tick logic below reads the pre-write *_q values.
      if (wr_data && (addr_q[3:2] == 2'(c))) begin
        per_full = 12'(period_q[c]);
        unique case (addr_q[1:0])
          2'd0: per_full[3:0]  = D;
          2'd1: per_full[7:4]  = D;
          2'd2: per_full[11:8] = D;
          2'd3: {mode_d[c], vol_d[c]} = D;
          default: ;
        endcase
        period_d[c] = per_full[PERIOD_W-1:0];
      end

      if (tick) begin
        if (period_q[c] == '0) begin
          cnt_d[c]   = '0;
          phase_d[c] = 1'b0;
        end else if (cnt_q[c] == '0) begin
          cnt_d[c] = period_q[c];
          if (mode_q[c]) begin
            lfsr_d[c]  = {lfsr_q[c][0] ^ lfsr_q[c][1], lfsr_q[c][14:1]};
            phase_d[c] = lfsr_q[c][1];
          end else begin
            phase_d[c] = ~phase_q[c];
          end
        end else begin
          cnt_d[c] = cnt_q[c] - PERIOD_W'(1);
        end
      end

      if (phase_q[c]) begin
        mix_d = mix_d + MIX_W'(vol_q[c]);
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      addr_q   <= '0;
      presc_q  <= '0;
      period_q <= '0;
      vol_q    <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      phase_q  <= '0;
      lfsr_q   <= {NUM_CH{15'h0001}};
      mix_q    <= '0;
    end else begin
      addr_q   <= addr_d;
      presc_q  <= presc_d;
      period_q <= period_d;
      vol_q    <= vol_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      lfsr_q   <= lfsr_d;
      mix_q    <= mix_d;
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      CH_OUT[c] = phase_q[c] & (vol_q[c] != 3'd0);
    end
  end

  assign MIX  = mix_q;
  assign TICK = tick;

endmodule

// File: tb/tb_psg_multichannel.sv
// Self-checking bench for psg_multichannel (4 channels, PRESCALE=4): per-cycle expectations
// are queued from an analytic view of channel events and compared as the DUT runs.
module tb_psg_multichannel;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] D   = 4'd0;
  logic       A0  = 1'b0;
  logic       WR  = 1'b0;
  logic [3:0] CH_OUT;
  logic [4:0] MIX;
  logic       TICK;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    int         n;
    logic [3:0] ch;
    logic [4:0] mix;
  } exp_t;

  exp_t sb[$];

  psg_multichannel #(
    .NUM_CH  (4),
    .PERIOD_W(12),
    .PRESCALE(4),
    .MIX_W   (5)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .D     (D),
    .A0    (A0),
    .WR    (WR),
    .CH_OUT(CH_OUT),
    .MIX   (MIX),
    .TICK  (TICK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // After edge n, cyc == n; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wr(input logic a0, input logic [3:0] d);
    WR = 1'b1;
    A0 = a0;
    D  = d;
    step();
    WR = 1'b0;
    A0 = 1'b0;
    D  = 4'd0;
  endtask

  task automatic idle_to(input int n);
    while (cyc < n) step();
  endtask

  // Releases reset just after an edge, so tick edges fall on cyc = 4, 8, 12, ...
  task automatic do_reset();
    RST = 1'b1;
    WR  = 1'b0;
    step();
    step();
    RST = 1'b0;
    cyc = 0;
  endtask

  // Square phase after edge n: first event at edge f, then a toggle every s cycles.
  function automatic logic sq(input int n, input int f, input int s);
    if (n < f) return 1'b0;
    return (((n - f) / s) % 2) == 0;
  endfunction

  task automatic test_reset();
    do_reset();
    if (CH_OUT !== 4'd0) begin
      $display("FAIL reset_ch_out got %b exp %b", CH_OUT, 4'd0); fails++;
    end
    checks++;
    if (MIX !== 5'd0) begin
      $display("FAIL reset_mix got %0d exp %0d", MIX, 0); fails++;
    end
    checks++;
    if (TICK !== 1'b0) begin
      $display("FAIL reset_tick got %b exp %b", TICK, 1'b0); fails++;
    end
    checks++;
    for (int n = 1; n <= 12; n++) begin
      step();
      if (TICK !== ((n % 4) == 3)) begin
        $display("FAIL tick_period n=%0d got %b exp %b", n, TICK, (n % 4) == 3); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_square();
    exp_t e;
    do_reset();
    wr(1'b1, 4'd0);
    wr(1'b0, 4'd2);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd7);
    for (int n = 6; n <= 53; n++) begin
      e.n   = n;
      e.ch  = {3'b000, sq(n, 4, 12)};
      e.mix = sq(n - 1, 4, 12) ? 5'd7 : 5'd0;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL square_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL square_mix n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_period_rewrite();
    exp_t e;
    logic ph, php;
    do_reset();
    wr(1'b1, 4'd0);
    wr(1'b0, 4'd3);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd7);
    idle_to(8);
    wr(1'b1, 4'd0);
    wr(1'b0, 4'd1);
    // Events at 4 and 20 (old period 3), then every 8 cycles from 28 (new period 1).
    for (int n = 11; n <= 70; n++) begin
      ph  = (n >= 4 && n < 20) ? 1'b1 : ((n < 28) ? 1'b0 : sq(n, 28, 8));
      php = (n - 1 >= 4 && n - 1 < 20) ? 1'b1 : ((n - 1 < 28) ? 1'b0 : sq(n - 1, 28, 8));
      e.n   = n;
      e.ch  = {3'b000, ph};
      e.mix = php ? 5'd7 : 5'd0;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL rewrite_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL rewrite_mix n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_addr_wrap();
    exp_t e;
    do_reset();
    wr(1'b1, 4'd12);
    wr(1'b0, 4'd1);
    wr(1'b1, 4'd15);
    wr(1'b0, 4'd5);
    // Address has wrapped to 0: these land in ch0 period and ch0 vol.
    wr(1'b0, 4'd3);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd6);
    for (int n = 9; n <= 56; n++) begin
      e.n   = n;
      e.ch  = {sq(n, 4, 8), 2'b00, sq(n, 8, 16)};
      e.mix = 5'((sq(n - 1, 4, 8) ? 5 : 0) + (sq(n - 1, 8, 16) ? 6 : 0));
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL wrap_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL wrap_mix n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_mix();
    exp_t e;
    int   sum;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      wr(1'b1, 4'(4 * c + 3));
      wr(1'b0, 4'd7);
    end
    // Enables spaced 16 cycles apart keep all four phases aligned (events every 8 cycles).
    for (int c = 0; c < 4; c++) begin
      idle_to(8 + 16 * c);
      wr(1'b1, 4'(4 * c));
      wr(1'b0, 4'd1);
    end
    for (int n = 59; n <= 110; n++) begin
      e.n = n;
      sum = 0;
      for (int c = 0; c < 4; c++) begin
        e.ch[c] = sq(n, 12 + 16 * c, 8);
        if (sq(n - 1, 12 + 16 * c, 8)) sum += 7;
      end
      e.mix = 5'(sum);
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL mix_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL mix_sum n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  // Assumes reset was released just after an edge (cyc = 0) with ADDR = 0.
  task automatic noise_body(input string tag);
    exp_t e;
    logic [14:0] lfsr;
    logic        ph, php;
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'd0);
    wr(1'b0, 4'hF);
    wr(1'b1, 4'd0);
    wr(1'b0, 4'd1);
    lfsr = 15'h0001;
    ph   = 1'b0;
    for (int n = 7; n <= 8 + 8 * 60; n++) begin
      php = ph;
      if (n >= 8 && ((n - 8) % 8) == 0) begin
        lfsr = {lfsr[0] ^ lfsr[1], lfsr[14:1]};
        ph   = lfsr[0];
      end
      e.n   = n;
      e.ch  = {3'b000, ph};
      e.mix = php ? 5'd7 : 5'd0;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL %s_ch_out n=%0d got %b exp %b", tag, e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL %s_mix n=%0d got %0d exp %0d", tag, e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  task automatic test_noise();
    do_reset();
    noise_body("noise");
  endtask

  // Follows test_mix with all channels running; ch0 is switched to noise to advance its LFSR.
  task automatic test_reset_midrun();
    wr(1'b1, 4'd3);
    wr(1'b0, 4'hF);
    repeat (100) step();
    WR  = 1'b1;
    A0  = 1'b0;
    D   = 4'd9;
    RST = 1'b1;
    #1;
    if (CH_OUT !== 4'd0) begin
      $display("FAIL midrun_ch_out got %b exp %b", CH_OUT, 4'd0); fails++;
    end
    checks++;
    if (MIX !== 5'd0) begin
      $display("FAIL midrun_mix got %0d exp %0d", MIX, 0); fails++;
    end
    checks++;
    if (TICK !== 1'b0) begin
      $display("FAIL midrun_tick got %b exp %b", TICK, 1'b0); fails++;
    end
    checks++;
    WR  = 1'b0;
    D   = 4'd0;
    #1;
    RST = 1'b0;
    cyc = 0;
    noise_body("midrun_noise");
  endtask

  task automatic test_period0_vol0();
    exp_t e;
    do_reset();
    wr(1'b1, 4'd7);
    wr(1'b0, 4'd7);
    wr(1'b1, 4'd8);
    // Lands on a tick edge: the first event uses the new period only from the next tick.
    wr(1'b0, 4'd3);
    for (int n = 5; n <= 40; n++) begin
      e.n   = n;
      e.ch  = 4'd0;
      e.mix = 5'd0;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL silent_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL silent_mix n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
    wr(1'b1, 4'd11);
    wr(1'b0, 4'd7);
    for (int n = 43; n <= 80; n++) begin
      e.n   = n;
      e.ch  = {1'b0, sq(n, 8, 16), 2'b00};
      e.mix = sq(n - 1, 8, 16) ? 5'd7 : 5'd0;
      sb.push_back(e);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      idle_to(e.n);
      if (CH_OUT !== e.ch) begin
        $display("FAIL vol_on_ch_out n=%0d got %b exp %b", e.n, CH_OUT, e.ch); fails++;
      end
      checks++;
      if (MIX !== e.mix) begin
        $display("FAIL vol_on_mix n=%0d got %0d exp %0d", e.n, MIX, e.mix); fails++;
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_square();
    test_period_rewrite();
    test_addr_wrap();
    test_mix();
    test_reset_midrun();
    test_period0_vol0();
    test_noise();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
